piso_register: RTL and testbench

PISO_REGISTER -- requirements
Module: piso_register

---
 rtl/piso_register.sv | 143 ++++++++++++++
 tb/tb_piso_register.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/piso_register.sv
// piso_register: parallel-in serial-out shift register with valid/ready load.
// A word accepted on pin is driven on sout one bit per cycle, starting the
// cycle after the accepting edge, in the order chosen by MSB_FIRST.
// Optional feature macro: PISO_PARITY_EN appends one even-parity bit per frame.
//
// Ports:
//   clk         sole clock, rising edge
//   rst_n       asynchronous active-low reset
//   pin         parallel word, sampled only on an accepted load
//   load_valid  requester offers pin
//   load_ready  block can accept a word this cycle (registered)
//   sout        serial data bit (registered)
//   sout_valid  sout carries a frame bit (registered)
//   done        one-cycle pulse on the final frame bit (registered)
module piso_register #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pin,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
`ifdef PISO_PARITY_EN
  localparam logic [1:0] PARITY = 2'd2;
`endif

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sout_d, valid_d, done_d, ready_d;
  logic             accept;
`ifdef PISO_PARITY_EN
  logic             parity_q, parity_d;
`endif

  // Bit that leaves the word next, in frame order.
  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
  endfunction

  // Word with the outgoing bit removed, remaining bits moved into place.
  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? (w << 1) : (w >> 1);
  endfunction

  assign accept = load_valid && load_ready;

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      cnt_q      <= '0;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      done       <= 1'b0;
      load_ready <= 1'b1;
`ifdef PISO_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      sout       <= sout_d;
      sout_valid <= valid_d;
      done       <= done_d;
      load_ready <= ready_d;
`ifdef PISO_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  // Next-state and next-output logic. cnt_q indexes the bit currently on sout.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    sout_d   = 1'b0;
    valid_d  = 1'b0;
    done_d   = 1'b0;
`ifdef PISO_PARITY_EN
    parity_d = parity_q;
`endif

    case (state_q)
      SHIFT: begin
        if (cnt_q != LAST) begin
          cnt_d   = cnt_q + CW'(1);
          sout_d  = first_bit(shreg_q);
          shreg_d = shift_word(shreg_q);
          valid_d = 1'b1;
`ifndef PISO_PARITY_EN
          done_d  = (cnt_d == LAST);
`endif
        end else begin
`ifdef PISO_PARITY_EN
          state_d = PARITY;
          sout_d  = parity_q;
          valid_d = 1'b1;
          done_d  = 1'b1;
`else
          state_d = IDLE;
`endif
        end
      end
`ifdef PISO_PARITY_EN
      PARITY: state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase

    // A load can only be accepted while idle or on the final frame bit,
    // so it overrides whatever the frame would have done next.
    if (accept) begin
      state_d  = SHIFT;
      cnt_d    = '0;
      sout_d   = first_bit(pin);
      shreg_d  = shift_word(pin);
      valid_d  = 1'b1;
      done_d   = 1'b0;
`ifdef PISO_PARITY_EN
      parity_d = ^pin;
`endif
    end

    // Ready next cycle when idle or when that cycle drives the final bit.
    ready_d = done_d || (state_d == IDLE);
  end

endmodule

// File: tb/tb_piso_register.sv
// Scoreboard bench for piso_register (WIDTH=4), one instance per bit order.
// Stimulus pushes the expected frame bits when a load is accepted; a negedge
// monitor pops and compares whatever the two instances present.
module tb_piso_register;

  typedef struct packed {
    logic bm;   // expected bit, MSB-first instance
    logic bl;   // expected bit, LSB-first instance
    logic fin;  // final bit of frame
  } exp_t;

  logic       clk, rst_n, load_valid;
  logic [3:0] pin;
  logic       ready_m, sout_m, valid_m, done_m;
  logic       ready_l, sout_l, valid_l, done_l;
  logic       mon_en;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  piso_register #(.WIDTH(4), .MSB_FIRST(1)) dut_m (
    .clk(clk), .rst_n(rst_n), .pin(pin), .load_valid(load_valid),
    .load_ready(ready_m), .sout(sout_m), .sout_valid(valid_m), .done(done_m)
  );

  piso_register #(.WIDTH(4), .MSB_FIRST(0)) dut_l (
    .clk(clk), .rst_n(rst_n), .pin(pin), .load_valid(load_valid),
    .load_ready(ready_l), .sout(sout_l), .sout_valid(valid_l), .done(done_l)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0b required=%0b t=%0t", name, act, req, $time);
    end
  endtask

  // Reference frame: data bits in each order, then optional even parity.
  task automatic push_frame(input logic [3:0] w);
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      e.bm = w[3-k];
      e.bl = w[k];
`ifdef PISO_PARITY_EN
      e.fin = 1'b0;
`else
      e.fin = (k == 3);
`endif
      q.push_back(e);
    end
`ifdef PISO_PARITY_EN
    e.bm  = ^w;
    e.bl  = ^w;
    e.fin = 1'b1;
    q.push_back(e);
`endif
  endtask

  // Monitor: front of queue is the bit expected on sout this cycle.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      chk("ready_m", ready_m, q.size() <= 1);
      chk("ready_l", ready_l, q.size() <= 1);
      if (q.size() == 0) begin
        chk("idle_valid_m", valid_m, 1'b0);
        chk("idle_valid_l", valid_l, 1'b0);
        chk("idle_sout_m", sout_m, 1'b0);
        chk("idle_sout_l", sout_l, 1'b0);
        chk("idle_done_m", done_m, 1'b0);
        chk("idle_done_l", done_l, 1'b0);
      end else begin
        e = q.pop_front();
        chk("valid_m", valid_m, 1'b1);
        chk("valid_l", valid_l, 1'b1);
        chk("sout_m", sout_m, e.bm);
        chk("sout_l", sout_l, e.bl);
        chk("done_m", done_m, e.fin);
        chk("done_l", done_l, e.fin);
      end
    end
  end

  // One cycle of stimulus; the load is accepted iff the model is ready.
  task automatic drive(input logic lv, input logic [3:0] p);
    @(negedge clk);
    #1;
    load_valid = lv;
    pin        = p;
    if (lv && rst_n && q.size() == 0) push_frame(p);
  endtask

  // Reset for n cycles with load_valid asserted (must be ignored);
  // optionally offer a word in the first cycle after release.
  task automatic do_reset(input int n, input logic lv_after, input logic [3:0] p);
    @(negedge clk);
    #1;
    rst_n      = 1'b0;
    load_valid = 1'b1;
    pin        = 4'($urandom);
    q.delete();
    #1;
    chk("rst_valid_m", valid_m, 1'b0);
    chk("rst_valid_l", valid_l, 1'b0);
    chk("rst_sout_m", sout_m, 1'b0);
    chk("rst_done_m", done_m, 1'b0);
    chk("rst_done_l", done_l, 1'b0);
    chk("rst_ready_m", ready_m, 1'b1);
    repeat (n) @(negedge clk);
    #1;
    rst_n      = 1'b1;
    load_valid = lv_after;
    pin        = p;
    if (lv_after) push_frame(p);
  endtask

  initial begin
    clk        = 1'b0;
    rst_n      = 1'b1;
    load_valid = 1'b0;
    pin        = '0;
    mon_en     = 1'b0;
    #2;
    rst_n  = 1'b0;
    #1;
    mon_en = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1;

    // Idle after reset.
    repeat (4) drive(1'b0, 4'b0000);

    // Single frame.
    drive(1'b1, 4'b1011);
    repeat (6) drive(1'b0, 4'b0000);

    // Held load_valid with changing pin, then back-to-back second word.
    drive(1'b1, 4'b1011);
    repeat (3) drive(1'b1, 4'b0000);
`ifdef PISO_PARITY_EN
    drive(1'b1, 4'b0000);
`endif
    drive(1'b1, 4'b0110);
    repeat (6) drive(1'b0, 4'b0000);

    // Reset mid-frame, then load immediately after release.
    drive(1'b1, 4'b1111);
    repeat (2) drive(1'b0, 4'b0000);
    do_reset(2, 1'b1, 4'b0001);
    repeat (6) drive(1'b0, 4'b0000);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 59) == 0)
        do_reset(int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), 4'($urandom));
      else
        drive(1'($urandom_range(0, 9) < 6), 4'($urandom));
    end

    repeat (8) drive(1'b0, 4'b0000);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0 pending bits", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
